// File: rtl/bbox_sample_iter_pkg.sv
// Shared raster types for the sample-grid iterator: fixed-point formats,
// triangle/box/sample payloads, FSM states and the subsample step helper.
package bbox_sample_iter_pkg;

   localparam int unsigned SIGFIG = 24;
   localparam int unsigned RADIX  = 10;
   localparam int unsigned VERTS  = 3;
   localparam int unsigned AXIS   = 3;
   localparam int unsigned COLORS = 3;

   typedef logic signed [SIGFIG-1:0] sfix_t;
   typedef logic        [SIGFIG-1:0] ufix_t;
   typedef logic signed [SIGFIG:0]   sfix_wide_t;

   typedef sfix_t [VERTS-1:0][AXIS-1:0] tri_t;
   typedef ufix_t [COLORS-1:0]          color_t;

   // x occupies the low word so that index [0]=x, [1]=y
   typedef struct packed {
      sfix_t y;
      sfix_t x;
   } sample_t;

   // ll occupies the low half so that index [0]=lower-left, [1]=upper-right
   typedef struct packed {
      sample_t ur;
      sample_t ll;
   } box_t;

   typedef enum logic {
      WAIT = 1'b0,
      WALK = 1'b1
   } state_e;

   // Distance between neighbouring subsamples in fixed point
   function automatic sfix_t ss_step(input logic [1:0] ss_w_lg2);
      return sfix_t'(ufix_t'(1) << (RADIX - 32'(ss_w_lg2)));
   endfunction

endpackage

// File: rtl/bbox_sample_iter_if.sv
// Bus between the bbox stage (master) and the sample iterator (slave),
// carrying both the R13 triangle handshake and the R14 sample stream.
interface bbox_sample_iter_if;
   import bbox_sample_iter_pkg::*;

   tri_t       tri_R13S;
   color_t     color_R13U;
   box_t       box_R13S;
   logic [1:0] ss_w_lg2_R13U;
   logic       validTri_R13H;
   logic       halt_RnnnnH;

   tri_t       tri_R14S;
   color_t     color_R14U;
   sample_t    sample_R14S;
   logic       validSamp_R14H;

   modport master (
      output tri_R13S, color_R13U, box_R13S, ss_w_lg2_R13U, validTri_R13H,
      input  halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );

   modport slave (
      input  tri_R13S, color_R13U, box_R13S, ss_w_lg2_R13U, validTri_R13H,
      output halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );

endinterface

// File: rtl/bbox_sample_iter_step_next.sv
// Raster-order successor of a sample inside a box; sums are one bit wider
// than the operands so that stepping past the box edge can never wrap.
module bbox_step_next
   import bbox_sample_iter_pkg::*;
(
   input  sample_t sample_i,
   input  sfix_t   ll_x_i,
   input  sample_t ur_i,
   input  sfix_t   step_i,
   output sample_t next_c,
   output logic    last_x_c,
   output logic    last_y_c,
   output logic    at_last_c
);

   sfix_wide_t sum_x;
   sfix_wide_t sum_y;

   always_comb begin
      sum_x     = sfix_wide_t'(sample_i.x) + sfix_wide_t'(step_i);
      sum_y     = sfix_wide_t'(sample_i.y) + sfix_wide_t'(step_i);
      last_x_c  = sum_x > sfix_wide_t'(ur_i.x);
      last_y_c  = sum_y > sfix_wide_t'(ur_i.y);
      at_last_c = last_x_c && last_y_c;

      next_c = sample_i;
      if (!last_x_c) begin
         next_c.x = sum_x[SIGFIG-1:0];
      end else if (!last_y_c) begin
         next_c.x = ll_x_i;
         next_c.y = sum_y[SIGFIG-1:0];
      end
   end

endmodule

// File: rtl/bbox_sample_iter.sv
// Walks every subsample of an accepted bounding box in raster order, one per
// cycle, stalling upstream until the final sample of the box is presented.
module bbox_sample_iter
   import bbox_sample_iter_pkg::*;
(
   input logic               clk,
   input logic               rst,
   bbox_sample_iter_if.slave bus
);

   state_e  state_q, state_d;
   tri_t    tri_q, tri_d;
   color_t  color_q, color_d;
   sfix_t   ll_x_q, ll_x_d;
   sample_t ur_q, ur_d;
   sfix_t   step_q, step_d;
   sample_t sample_q, sample_d;
   logic    valid_samp_q, valid_samp_d;

   sample_t next_c;
   logic    last_x_c, last_y_c, at_last_c;
   logic    box_empty_c, halt_c, accept_c;

   bbox_step_next u_step_next (
      .sample_i  (sample_q),
      .ll_x_i    (ll_x_q),
      .ur_i      (ur_q),
      .step_i    (step_q),
      .next_c    (next_c),
      .last_x_c  (last_x_c),
      .last_y_c  (last_y_c),
      .at_last_c (at_last_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= WAIT;
         tri_q        <= '0;
         color_q      <= '0;
         ll_x_q       <= '0;
         ur_q         <= '0;
         step_q       <= '0;
         sample_q     <= '0;
         valid_samp_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tri_q        <= tri_d;
         color_q      <= color_d;
         ll_x_q       <= ll_x_d;
         ur_q         <= ur_d;
         step_q       <= step_d;
         sample_q     <= sample_d;
         valid_samp_q <= valid_samp_d;
      end
   end

   // Halt is low in WAIT and on the final sample, so accepting covers both
   // a fresh start and a gapless hand-over to the next triangle.
   always_comb begin
      state_d  = state_q;
      tri_d    = tri_q;
      color_d  = color_q;
      ll_x_d   = ll_x_q;
      ur_d     = ur_q;
      step_d   = step_q;
      sample_d = sample_q;

      box_empty_c = (bus.box_R13S.ur.x < bus.box_R13S.ll.x) ||
                    (bus.box_R13S.ur.y < bus.box_R13S.ll.y);
      halt_c      = (state_q == WALK) && !at_last_c;
      accept_c    = bus.validTri_R13H && !halt_c && !box_empty_c;

      if (accept_c) begin
         state_d  = WALK;
         tri_d    = bus.tri_R13S;
         color_d  = bus.color_R13U;
         ll_x_d   = bus.box_R13S.ll.x;
         ur_d     = bus.box_R13S.ur;
         step_d   = ss_step(bus.ss_w_lg2_R13U);
         sample_d = bus.box_R13S.ll;
      end else if (state_q == WALK) begin
         if (!at_last_c) begin
            sample_d = next_c;
         end else begin
            state_d = WAIT;
         end
      end

      valid_samp_d = (state_d == WALK);
   end

   assign bus.halt_RnnnnH    = halt_c;
   assign bus.tri_R14S       = tri_q;
   assign bus.color_R14U     = color_q;
   assign bus.sample_R14S    = sample_q;
   assign bus.validSamp_R14H = valid_samp_q;

endmodule

// File: tb/tb_bbox_sample_iter.sv
// Directed bench for bbox_sample_iter: raster order, step sizes, back-to-back
// triangles, single-sample and empty boxes, and asynchronous reset mid-walk.
module tb_bbox_sample_iter;
   import bbox_sample_iter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   bbox_sample_iter_if bus ();

   bbox_sample_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic sample_t smp(input int x, input int y);
      sample_t s;
      s.x = sfix_t'(x);
      s.y = sfix_t'(y);
      return s;
   endfunction

   function automatic box_t mkbox(input int llx, input int lly, input int urx, input int ury);
      box_t b;
      b.ll = smp(llx, lly);
      b.ur = smp(urx, ury);
      return b;
   endfunction

   function automatic tri_t mktri(input int seed);
      tri_t t;
      for (int v = 0; v < int'(VERTS); v++)
         for (int a = 0; a < int'(AXIS); a++)
            t[v][a] = sfix_t'(seed * 1000 + v * 10 + a + 1);
      return t;
   endfunction

   function automatic color_t mkcol(input int seed);
      color_t c;
      for (int i = 0; i < int'(COLORS); i++)
         c[i] = ufix_t'(seed * 77 + i + 5);
      return c;
   endfunction

   task automatic drive(input int seed, input box_t b, input logic [1:0] ss, input logic v);
      bus.tri_R13S      = mktri(seed);
      bus.color_R13U    = mkcol(seed);
      bus.box_R13S      = b;
      bus.ss_w_lg2_R13U = ss;
      bus.validTri_R13H = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_samp(input string tag, input logic h, input sample_t s, input int seed);
      chk({tag, "_valid"}, 256'(bus.validSamp_R14H), 256'(1'b1));
      chk({tag, "_halt"},  256'(bus.halt_RnnnnH), 256'(h));
      chk({tag, "_sample"}, 256'(bus.sample_R14S), 256'(s));
      chk({tag, "_tri"},   256'(bus.tri_R14S), 256'(mktri(seed)));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 256'(bus.validSamp_R14H), 256'(1'b0));
      chk({tag, "_halt"},  256'(bus.halt_RnnnnH), 256'(1'b0));
   endtask

   initial begin
      rst = 1'b1;
      bus.tri_R13S      = '0;
      bus.color_R13U    = '0;
      bus.box_R13S      = '0;
      bus.ss_w_lg2_R13U = '0;
      bus.validTri_R13H = 1'b0;
      tick();
      tick();
      chk_idle("reset");
      chk("reset_sample", 256'(bus.sample_R14S), 256'(0));
      chk("reset_tri",    256'(bus.tri_R14S), 256'(0));
      chk("reset_color",  256'(bus.color_R14U), 256'(0));
      rst = 1'b0;
      tick();
      chk_idle("post_reset");

      // 3x2 box at step 1024
      drive(1, mkbox(0, 0, 2048, 1024), 2'd0, 1'b1);
      tick();
      bus.validTri_R13H = 1'b0;
      chk("t1_color", 256'(bus.color_R14U), 256'(mkcol(1)));
      for (int i = 0; i < 6; i++) begin
         chk_samp("t1", logic'(i < 5), smp((i % 3) * 1024, (i / 3) * 1024), 1);
         tick();
      end
      chk_idle("t1_end");

      // single row at step 128
      drive(2, mkbox(0, 0, 896, 0), 2'd3, 1'b1);
      tick();
      bus.validTri_R13H = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_samp("t2", logic'(i < 7), smp(i * 128, 0), 2);
         tick();
      end
      chk_idle("t2_end");

      // back-to-back: triangle 4 waits while halted, then follows with no gap
      drive(3, mkbox(0, 0, 1024, 0), 2'd0, 1'b1);
      tick();
      drive(4, mkbox(0, 0, 0, 1024), 2'd0, 1'b1);
      chk_samp("t3a0", 1'b1, smp(0, 0), 3);
      tick();
      chk_samp("t3a1", 1'b0, smp(1024, 0), 3);
      tick();
      bus.validTri_R13H = 1'b0;
      chk_samp("t3b0", 1'b1, smp(0, 0), 4);
      chk("t3b_color", 256'(bus.color_R14U), 256'(mkcol(4)));
      tick();
      chk_samp("t3b1", 1'b0, smp(0, 1024), 4);
      tick();
      chk_idle("t3_end");

      // single-sample box
      drive(5, mkbox(1024, 1024, 1024, 1024), 2'd0, 1'b1);
      tick();
      bus.validTri_R13H = 1'b0;
      chk_samp("t4", 1'b0, smp(1024, 1024), 5);
      tick();
      chk_idle("t4_end");

      // empty box is dropped; the next triangle goes straight in
      drive(6, mkbox(2048, 0, 1024, 0), 2'd0, 1'b1);
      tick();
      chk_idle("t5_drop");
      chk("t5_tri_kept", 256'(bus.tri_R14S), 256'(mktri(5)));
      drive(7, mkbox(1024, 1024, 1024, 1024), 2'd0, 1'b1);
      tick();
      bus.validTri_R13H = 1'b0;
      chk_samp("t5_next", 1'b0, smp(1024, 1024), 7);
      tick();
      chk_idle("t5_end");

      // reset lands on the third sample of a 6-sample walk
      drive(8, mkbox(0, 0, 2048, 1024), 2'd0, 1'b1);
      tick();
      bus.validTri_R13H = 1'b0;
      chk_samp("t6_s0", 1'b1, smp(0, 0), 8);
      tick();
      chk_samp("t6_s1", 1'b1, smp(1024, 0), 8);
      tick();
      chk_samp("t6_s2", 1'b1, smp(2048, 0), 8);
      rst = 1'b1;
      #1;
      chk_idle("t6_rst");
      chk("t6_rst_sample", 256'(bus.sample_R14S), 256'(0));
      chk("t6_rst_tri",    256'(bus.tri_R14S), 256'(0));
      chk("t6_rst_color",  256'(bus.color_R14U), 256'(0));
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk_idle("t6_released");
      drive(9, mkbox(1024, 1024, 2048, 1024), 2'd0, 1'b1);
      tick();
      bus.validTri_R13H = 1'b0;
      chk_samp("t6_fresh0", 1'b1, smp(1024, 1024), 9);
      tick();
      chk_samp("t6_fresh1", 1'b0, smp(2048, 1024), 9);
      tick();
      chk_idle("t6_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
